// File: rtl/multicycle_ctl.sv
// Multi-cycle MIPS32 main control FSM: sequences ALU, shared memory port and register file.
// 3-5 states per instruction; FETCH/MEMRD/MEMWR hold state and strobes until MemReady.
module multicycle_ctl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRd,
  output logic       MemWr,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWr,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ILLEGAL = 4'd10
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  state_t     state;
  state_t     next_state;
  logic [5:0] op_q;

  // Opcode is captured in DECODE so MEMADR does not depend on the IR staying stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      op_q  <= 6'b000000;
    end else begin
      state <= next_state;
      if (state == DECODE) op_q <= OpCode;
    end
  end

  assign State = state;

  always_comb begin
    next_state  = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRd       = 1'b0;
    MemWr       = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWr       = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    InstrDone   = 1'b0;
    Illegal     = 1'b0;

    case (state)
      FETCH: begin
        MemRd   = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) next_state = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (OpCode)
          OP_R:         next_state = EXEC;
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          default:      next_state = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (op_q == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRd = 1'b1;
        IorD  = 1'b1;
        if (MemReady) next_state = MEMWB;
      end
      MEMWB: begin
        RegWr      = 1'b1;
        MemtoReg   = 1'b1;
        InstrDone  = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        MemWr     = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
        if (MemReady) next_state = FETCH;
      end
      EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        next_state = RWB;
      end
      RWB: begin
        RegWr      = 1'b1;
        RegDst     = 1'b1;
        InstrDone  = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        InstrDone   = 1'b1;
        next_state  = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        InstrDone  = 1'b1;
        next_state = FETCH;
      end
      ILLEGAL: begin
        Illegal    = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase

    // Reset kills every side effect immediately, even mid memory wait.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemRd       = 1'b0;
      MemWr       = 1'b0;
      RegWr       = 1'b0;
      InstrDone   = 1'b0;
      Illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctl.sv
// Directed bench for multicycle_ctl: expected state/control words queued per cycle, checked at negedge.
module tb_multicycle_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OpCode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite;
  logic       MemtoReg, RegDst, RegWr, ALUSrcA, InstrDone, Illegal;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] State;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  multicycle_ctl dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWr(RegWr),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .InstrDone(InstrDone), .Illegal(Illegal), .State(State)
  );

  wire [17:0] ctl = {PCWrite, PCWriteCond, PCSource, IorD, MemRd, MemWr, IRWrite,
                     MemtoReg, RegDst, RegWr, ALUSrcA, ALUSrcB, ALUOp, InstrDone, Illegal};

  // Expected control word for a state, straight from the per-state output table.
  function automatic logic [17:0] model(input logic [3:0] s, input logic mr, input logic r);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, done, ill;
    logic [1:0] pcs, asb, aop;
    pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0;
    rdst = 0; rwr = 0; asa = 0; done = 0; ill = 0; pcs = 0; asb = 0; aop = 0;
    case (s)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rwr = 1; m2r = 1; done = 1; end
      4'd5:  begin mwr = 1; iord = 1; done = mr; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rwr = 1; rdst = 1; done = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      4'd9:  begin pcw = 1; pcs = 2'b10; done = 1; end
      4'd10: ill = 1;
      default: ;
    endcase
    if (r) begin
      pcw = 0; pcwc = 0; irw = 0; mrd = 0; mwr = 0; rwr = 0; done = 0; ill = 0;
    end
    return {pcw, pcwc, pcs, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, done, ill};
  endfunction

  task automatic step(input logic [5:0] op, input logic mr, input logic r,
                      input logic [3:0] es, input string tag);
    exp_t e;
    OpCode = op;
    MemReady = mr;
    rst = r;
    q.push_back('{st: es, ctl: model(es, mr, r)});
    @(negedge clk);
    e = q.pop_front();
    checks++;
    assert (State === e.st) else begin
      failures++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, State, e.st);
    end
    checks++;
    assert (ctl === e.ctl) else begin
      failures++;
      $error("FAIL %s ctl observed=%05h expected=%05h", tag, ctl, e.ctl);
    end
    if (InstrDone === 1'b1) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input int obs, input int expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; OpCode = 6'd0; MemReady = 1'b0;
    @(posedge clk); #1;
    step(R, 1, 1, 0, "reset");

    // R-type: 0,1,6,7
    done_cnt = 0;
    step(R, 1, 0, 0, "r_fetch");
    step(R, 1, 0, 1, "r_decode");
    step(R, 1, 0, 6, "r_exec");
    step(R, 1, 0, 7, "r_rwb");
    check_cnt(done_cnt, 1, "r_done_cnt");

    // LW with 2 fetch waits and 3 memrd waits
    step(LW, 0, 0, 0, "lw_fetch_w1");
    step(LW, 0, 0, 0, "lw_fetch_w2");
    step(LW, 1, 0, 0, "lw_fetch");
    step(LW, 1, 0, 1, "lw_decode");
    step(LW, 1, 0, 2, "lw_memadr");
    step(LW, 0, 0, 3, "lw_memrd_w1");
    step(LW, 0, 0, 3, "lw_memrd_w2");
    step(LW, 0, 0, 3, "lw_memrd_w3");
    step(LW, 1, 0, 3, "lw_memrd");
    step(LW, 1, 0, 4, "lw_memwb");

    // SW, BEQ, J back to back
    done_cnt = 0;
    step(SW, 1, 0, 0, "sw_fetch");
    step(SW, 1, 0, 1, "sw_decode");
    step(SW, 1, 0, 2, "sw_memadr");
    step(SW, 1, 0, 5, "sw_memwr");
    step(BEQ, 1, 0, 0, "beq_fetch");
    step(BEQ, 1, 0, 1, "beq_decode");
    step(BEQ, 1, 0, 8, "beq_branch");
    step(J, 1, 0, 0, "j_fetch");
    step(J, 1, 0, 1, "j_decode");
    step(J, 1, 0, 9, "j_jump");
    check_cnt(done_cnt, 3, "sbj_done_cnt");

    // Unsupported opcode
    step(ADDI, 1, 0, 0, "ill_fetch");
    step(ADDI, 1, 0, 1, "ill_decode");
    step(ADDI, 1, 0, 10, "ill_state");

    // Opcode changes after DECODE: latched LW still selects MEMRD
    step(LW, 1, 0, 0, "lat_fetch");
    step(LW, 1, 0, 1, "lat_decode");
    step(R, 1, 0, 2, "lat_memadr");
    step(R, 1, 0, 3, "lat_memrd");
    step(R, 1, 0, 4, "lat_memwb");

    // Reset during a MEMRD wait
    step(LW, 1, 0, 0, "rst_fetch");
    step(LW, 1, 0, 1, "rst_decode");
    step(LW, 1, 0, 2, "rst_memadr");
    step(LW, 0, 0, 3, "rst_memrd_w");
    step(LW, 0, 1, 3, "rst_assert");
    step(R, 1, 0, 0, "rst_refetch");
    step(R, 1, 0, 1, "rst_redecode");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
